// File: rtl/pipe_pkg.sv
// Shared types and constants for the two-entry pipeline stage register.
// Included by pipe_slot and pipe_stage_reg.
package pipe_pkg;

  localparam int DEFAULT_ADDR_W  = 32;
  localparam int DEFAULT_INSTR_W = 32;

  // Index of each storage slot in the slot arrays of the top level
  localparam int SLOT_MAIN = 0;
  localparam int SLOT_SKID = 1;
  localparam int NUM_SLOTS = 2;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0]  pc;
    logic [DEFAULT_INSTR_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/pipe_slot.sv
// One {pc, instr} entry register: loadable, synchronously clearable,
// asynchronously reset to zero. Clear wins over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADDR_W + DEFAULT_INSTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (clear) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= d;
    end
  end

  assign q = data_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage with freeze/flush control.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/flush_cnt counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               freeze,
  input  logic               flush
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;

  state_t state_reg;
  state_t state_next;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] slot_d    [NUM_SLOTS];
  logic [ENTRY_W-1:0] slot_q    [NUM_SLOTS];
  logic               slot_load [NUM_SLOTS];
  logic               main_from_skid;
  logic               accept;
  logic               pop;

  assign in_entry = {in_pc, in_instr};

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------
  // Next-state and slot-load decode
  // ---------------------------------------------------------------
  always_comb begin
    state_next              = state_reg;
    slot_load[SLOT_MAIN]    = 1'b0;
    slot_load[SLOT_SKID]    = 1'b0;
    main_from_skid          = 1'b0;

    // freeze already masks accept and pop, so it needs no term here
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next           = ONE;
          slot_load[SLOT_MAIN] = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          state_next           = ONE;
          slot_load[SLOT_MAIN] = 1'b1;
        end else if (accept) begin
          state_next           = TWO;
          slot_load[SLOT_SKID] = 1'b1;
        end else if (pop) begin
          state_next           = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next           = ONE;
          slot_load[SLOT_MAIN] = 1'b1;
          main_from_skid       = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    if (flush) begin
      state_next = EMPTY;
    end
  end

  // ---------------------------------------------------------------
  // Outputs: decoded from registered state and freeze only
  // ---------------------------------------------------------------
  always_comb begin
    in_ready  = (state_reg != TWO) && !freeze;
    out_valid = (state_reg != EMPTY) && !freeze;
  end

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  assign slot_d[SLOT_MAIN] = main_from_skid ? slot_q[SLOT_SKID] : in_entry;
  assign slot_d[SLOT_SKID] = in_entry;

  // ---------------------------------------------------------------
  // Storage slots
  // ---------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      pipe_slot #(
        .WIDTH (ENTRY_W)
      ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (slot_load[gi]),
        .clear (flush),
        .d     (slot_d[gi]),
        .q     (slot_q[gi])
      );
    end
  endgenerate

  assign out_pc    = slot_q[SLOT_MAIN][ENTRY_W-1 -: ADDR_W];
  assign out_instr = slot_q[SLOT_MAIN][INSTR_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
  // ---------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             stall_event;

  assign stall_event = freeze && (state_reg != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_event && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (flush && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule
